// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// sequential divider. It picks a requester, registers its operands, pulses
// the divider start, waits for div_ready (bounded by TIMEOUT cycles) and
// returns the quotient to the owner with a one-cycle done pulse.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous, active-low reset
//   req            per-requester level request
//   dividendo_in   packed dividends, slice i = [i*BITS +: BITS]
//   divisor_in     packed divisors, same packing
//   grant          one-hot owner of the divider, zero when idle
//   done           one-cycle completion pulse to the owner
//   result         quotient, held until the next done
//   err            high with done when the quotient was forced (x/0 or timeout)
//   div_dividendo  registered dividend to the divider
//   div_divisor    registered divisor to the divider
//   div_reset      active-high one-cycle start pulse to the divider
//   div_result     divider quotient
//   div_ready      divider completion flag
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BITS    = 60,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*BITS-1:0] dividendo_in,
  input  logic [NUM_REQ*BITS-1:0] divisor_in,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [BITS-1:0]         result,
  output logic                    err,
  output logic [BITS-1:0]         div_dividendo,
  output logic [BITS-1:0]         div_divisor,
  output logic                    div_reset,
  input  logic [BITS-1:0]         div_result,
  input  logic                    div_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_DIV = 2'd2,
    RESPOND  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [BITS-1:0]      result_q, result_d;
  logic                 err_q, err_d;
  logic                 div_reset_q, div_reset_d;
  logic [BITS-1:0]      dvd_q, dvd_d;
  logic [BITS-1:0]      dvs_q, dvs_d;

  logic [BITS-1:0]      dvd_s [NUM_REQ];
  logic [BITS-1:0]      dvs_s [NUM_REQ];
  logic [IDX_W-1:0]     pick_s;
  logic [IDX_W-1:0]     cand_s;
  logic                 pick_vld_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dvd_s[g] = dividendo_in[g*BITS +: BITS];
    assign dvs_s[g] = divisor_in[g*BITS +: BITS];
  end

  // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = rr_ptr_q;
    cand_s     = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s     = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      pick_s     = (req[cand_s] && !pick_vld_s) ? cand_s : pick_s;
      pick_vld_s = pick_vld_s | req[cand_s];
    end
  end

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    grant_d     = grant_q;
    done_d      = '0;
    result_d    = result_q;
    err_d       = 1'b0;
    div_reset_d = 1'b0;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          winner_d    = pick_s;
          grant_d     = NUM_REQ'(1'b1) << pick_s;
          dvd_d       = dvd_s[pick_s];
          dvs_d       = dvs_s[pick_s];
          zero_d      = (dvs_s[pick_s] == '0);
          // The divider is never started for a zero divisor.
          div_reset_d = (dvs_s[pick_s] != '0);
          state_d     = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        cnt_d = '0;
        // A zero divisor passes through LAUNCH without a start pulse so that
        // its done lands two cycles after the pick.
        if (zero_q) begin
          state_d  = RESPOND;
          done_d   = grant_q;
          result_d = '1;
          err_d    = 1'b1;
        end else begin
          state_d = WAIT_DIV;
        end
      end
      WAIT_DIV: begin
        // cnt_q == 0 marks the first WAIT_DIV cycle, where div_ready is stale.
        if ((cnt_q != '0) && div_ready) begin
          state_d  = RESPOND;
          done_d   = grant_q;
          result_d = div_result;
          err_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESPOND;
          done_d   = grant_q;
          result_d = '1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      RESPOND: begin
        grant_d  = '0;
        rr_ptr_d = (winner_q == IDX_LAST) ? '0 : winner_q + IDX_W'(1'b1);
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      div_reset_q <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      div_reset_q <= div_reset_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign result        = result_q;
  assign err           = err_q;
  assign div_reset     = div_reset_q;
  assign div_dividendo = dvd_q;
  assign div_divisor   = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: a behavioural divider with configurable latency
// (its ready stays stale-high until a new start is absorbed) and a
// round-robin / quotient reference model computed with plain arithmetic.
module tb_div_arbiter;
  localparam int N   = 4;
  localparam int W   = 60;
  localparam int TMO = 8;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [W-1:0]   dvd_a [N];
  logic [W-1:0]   dvs_a [N];
  logic [N*W-1:0] dvd_in, dvs_in;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   result, div_dividendo, div_divisor, div_result;
  logic           err, div_reset, div_ready;

  assign dvd_in = {dvd_a[3], dvd_a[2], dvd_a[1], dvd_a[0]};
  assign dvs_in = {dvs_a[3], dvs_a[2], dvs_a[1], dvs_a[0]};

  div_arbiter #(.NUM_REQ(N), .BITS(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .dividendo_in(dvd_in), .divisor_in(dvs_in),
    .grant(grant), .done(done), .result(result), .err(err),
    .div_dividendo(div_dividendo), .div_divisor(div_divisor),
    .div_reset(div_reset), .div_result(div_result), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  // Behavioural divider: start absorbed one cycle after div_reset, ready
  // cleared then, quotient presented lat_cur cycles later.
  logic         tb_rdy = 1'b1;
  logic [W-1:0] tb_res = 60'h0000000000000BAD;
  logic [W-1:0] q_hold = '0;
  logic         pend = 1'b0;
  int           dcnt = 0;
  int           lat_cur = 3;
  bit           stuck_low = 1'b0;

  assign div_ready  = stuck_low ? 1'b0 : tb_rdy;
  assign div_result = tb_res;

  always @(posedge clk) begin
    pend <= div_reset;
    if (pend) begin
      tb_rdy <= 1'b0;
      dcnt   <= lat_cur;
      q_hold <= (div_divisor == '0) ? ALL1 : div_dividendo / div_divisor;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        tb_rdy <= 1'b1;
        tb_res <= q_hold;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;
  int done_pulses = 0;
  bit mon_en = 1'b0;
  int model_ptr = 0;

  // Per-cycle monitor: grant one-hot, pulse counters.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(grant)) else begin
        errors++;
        $error("FAIL grant_onehot: got %b expected one-hot or zero", grant);
      end
      rst_pulses  += int'(div_reset);
      done_pulses += int'(done != '0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] rnd_dvs();
    if ($urandom_range(0, 5) == 0) return '0;
    if ($urandom_range(0, 1) == 0) return W'($urandom_range(1, 100000));
    return rnd_w() >> $urandom_range(0, 40);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_divrst"}, 64'(div_reset), 64'd0);
    chk({tag, "_divdvd"}, 64'(div_dividendo), 64'd0);
    chk({tag, "_divdvs"}, 64'(div_divisor), 64'd0);
  endtask

  // One arbitration round: starts in an IDLE cycle, ends in the IDLE cycle
  // after done. Expected winner, quotient, err and latency come from the model.
  task automatic serve(input string tag, input logic [N-1:0] mask, input bit drop);
    int           w, cyc, exp_cyc, rst0;
    logic [W-1:0] exp_q;
    logic         exp_e, zero;
    logic [N-1:0] oh;
    w    = rr_pick(mask, model_ptr);
    oh   = N'(1) << w;
    zero = (dvs_a[w] == '0);
    if (zero) begin
      exp_q = ALL1; exp_e = 1'b1; exp_cyc = 2;
    end else if (stuck_low) begin
      exp_q = ALL1; exp_e = 1'b1; exp_cyc = 2 + TMO;
    end else begin
      exp_q = dvd_a[w] / dvs_a[w]; exp_e = 1'b0; exp_cyc = 4 + lat_cur;
    end
    rst0 = rst_pulses;
    req  = mask;
    tick();
    cyc = 1;
    chk({tag, "_grant1"}, 64'(grant), 64'(oh));
    chk({tag, "_divrst1"}, 64'(div_reset), 64'(!zero));
    chk({tag, "_divdvd"}, 64'(div_dividendo), 64'(dvd_a[w]));
    chk({tag, "_divdvs"}, 64'(div_divisor), 64'(dvs_a[w]));
    if (drop) req = '0;
    // operands change after the pick; the result must not follow them
    dvd_a[w] = rnd_w();
    dvs_a[w] = rnd_dvs();
    while (done == '0 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_done"}, 64'(done), 64'(oh));
    chk({tag, "_result"}, 64'(result), 64'(exp_q));
    chk({tag, "_err"}, 64'(err), 64'(exp_e));
    chk({tag, "_grant_resp"}, 64'(grant), 64'(oh));
    chk({tag, "_start_pulses"}, 64'(rst_pulses - rst0), zero ? 64'd0 : 64'd1);
    model_ptr = (w + 1) % N;
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_grant_drop"}, 64'(grant), 64'd0);
  endtask

  initial begin
    int done0;
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      dvd_a[i] = '0;
      dvs_a[i] = '0;
    end
    tick();
    tick();
    chk_reset_outputs("reset");
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // single request 100/7 on requester 2
    dvd_a[2] = 60'd100; dvs_a[2] = 60'd7; lat_cur = 3;
    serve("single", 4'b0100, 1'b0);

    // divide by zero on requester 1
    dvd_a[1] = 60'd5; dvs_a[1] = 60'd0;
    serve("div0", 4'b0010, 1'b0);

    // timeout with div_ready held low
    dvd_a[0] = 60'd1000; dvs_a[0] = 60'd3; stuck_low = 1'b1;
    serve("timeout", 4'b0001, 1'b0);
    stuck_low = 1'b0;

    // request withdrawn right after the grant
    dvd_a[3] = 60'd123456789; dvs_a[3] = 60'd1000; lat_cur = 2;
    serve("withdrawn", 4'b1000, 1'b1);

    // full contention from rr_ptr 0: order 0,1,2,3,0
    for (int i = 0; i < N; i++) begin
      dvd_a[i] = 60'd900 + 60'(i); dvs_a[i] = 60'd3 + 60'(i);
    end
    for (int i = 0; i < 5; i++) begin
      lat_cur = 1 + i;
      serve("contend", 4'b1111, 1'b0);
    end

    // reset in the middle of WAIT_DIV
    dvd_a[2] = 60'd77; dvs_a[2] = 60'd5; lat_cur = 5;
    done0 = done_pulses;
    req = 4'b0100;
    tick();
    chk("midrst_grant", 64'(grant), 64'b0100);
    req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b1;
    model_ptr = 0;
    repeat (10) tick();
    chk("midrst_no_done", 64'(done_pulses), 64'(done0));
    lat_cur = 2;
    dvd_a[0] = 60'd50; dvs_a[0] = 60'd6;
    serve("post_rst", 4'b1101, 1'b0);

    // randomized rounds against the model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        dvd_a[i] = rnd_w();
        dvs_a[i] = rnd_dvs();
      end
      lat_cur = $urandom_range(1, 5);
      serve("rand", 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
